// File: rtl/lsu_dbus.sv
// lsu_dbus: load/store unit between the multi-cycle control unit and the data bus.
//
// Takes the EXEC-phase load/store strobes, funct3, the effective address and rs2.
// It then runs one request/acknowledge transaction on a 32-bit data bus and
// stalls the control unit through hold until the access finishes.
// Misaligned and illegal accesses are rejected without a bus cycle.
// A bus that never acknowledges is cut off after TIMEOUT request cycles.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   exec, dbus_re, dbus_we    control unit EXEC state and load/store strobes
//   funct3, addr, store_data  access width/sign, effective address, rs2
//   hold                      stall to the control unit
//   load_data, load_valid     extended load result and its 1-cycle valid
//   fault, fault_cause        1-cycle fault pulse; cause 1 misaligned, 2 timeout, 3 illegal
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   data-bus request side
//   bus_ack, bus_rdata        data-bus completion side
module lsu_dbus #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec,
  input  logic              dbus_re,
  input  logic              dbus_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              hold,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISALGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic                we_q, we_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         ld_q, ld_d;
  logic [1:0]          cause_q, cause_d;

  logic new_req, illegal, misal;

  // Byte enables for an access of size sz (funct3[1:0]) at byte offset off.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it may land in.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero extend by funct3.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extract = {24'd0, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extract = {16'd0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  always_comb begin
    new_req = exec & (dbus_re | dbus_we);
    illegal = (dbus_re & dbus_we) |
              (dbus_re & ((funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7))) |
              (dbus_we & (funct3 >= 3'd3));
    misal   = ((funct3[1:0] == 2'b01) & addr[0]) |
              ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    f3_d       = f3_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    ld_d       = ld_q;
    cause_d    = cause_q;
    hold       = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    load_valid = 1'b0;
    fault      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Combinational so the control unit cannot leave EXEC on this edge.
        hold = new_req;
        if (new_req) begin
          f3_d  = funct3;
          off_d = addr[1:0];
          we_d  = dbus_we;
          cnt_d = '0;
          if (illegal) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_DONE;
          end else if (misal) begin
            cause_d = CAUSE_MISALGN;
            state_d = S_DONE;
          end else begin
            cause_d = CAUSE_NONE;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = lane_be(funct3[1:0], addr[1:0]);
            wdata_d = lane_wdata(funct3[1:0], store_data);
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        hold    = 1'b1;
        bus_req = 1'b1;
        bus_we  = we_q;
        // Ack is tested first so it wins over a same-edge timeout.
        if (bus_ack) begin
          if (!we_q) ld_d = extract(f3_q, off_q, bus_rdata);
          cause_d = CAUSE_NONE;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // exec and the strobes are still high here; they must not restart.
        load_valid = !we_q && (cause_q == CAUSE_NONE);
        fault      = (cause_q != CAUSE_NONE);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // hold is the only output not derived purely from reset registers.
    if (!rst) hold = 1'b0;
  end

  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign load_data   = ld_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu_dbus.sv
module tb_lsu_dbus;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exec = 1'b0;
  logic        dbus_re = 1'b0;
  logic        dbus_we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        hold;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_dbus #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .exec       (exec),
    .dbus_re    (dbus_re),
    .dbus_we    (dbus_we),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .hold       (hold),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault),
    .fault_cause(fault_cause),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          waits;      // REQ cycles before ack; -1 = never ack
    int          exp_hold;
    int          exp_req;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_lv;
    logic [31:0] exp_ld;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t        e;
    int          hold_cnt = 0;
    int          req_cnt  = 0;
    bit          done     = 0;
    bit          spurious = 0;
    bit          unstable = 0;
    logic [31:0] a0 = '0;
    logic [31:0] wd0 = '0;
    logic [3:0]  be0 = '0;
    logic        we0 = 1'b0;
    @(negedge clk);
    exec = 1'b1; dbus_re = v.re; dbus_we = v.we; funct3 = v.f3;
    addr = v.addr; store_data = v.sdata;
    sb.push_back(v);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (!hold) begin
        done = 1;
        exec = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0; bus_ack = 1'b0;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL v%0d scoreboard: got empty queue required one entry", idx);
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d hold_cycles", idx), 32'(hold_cnt), 32'(e.exp_hold));
          check($sformatf("v%0d req_cycles", idx), 32'(req_cnt), 32'(e.exp_req));
          check($sformatf("v%0d done_bus_req", idx), 32'(bus_req), 32'd0);
          check($sformatf("v%0d load_valid", idx), 32'(load_valid), 32'(e.exp_lv));
          check($sformatf("v%0d fault", idx), 32'(fault), 32'(e.exp_cause != 2'd0));
          check($sformatf("v%0d fault_cause", idx), 32'(fault_cause), 32'(e.exp_cause));
          check($sformatf("v%0d load_data", idx), load_data, e.exp_ld);
          check($sformatf("v%0d early_pulse", idx), 32'(spurious), 32'd0);
          if (e.exp_req > 0) begin
            check($sformatf("v%0d bus_addr", idx), a0, e.exp_baddr);
            check($sformatf("v%0d bus_be", idx), 32'(be0), 32'(e.exp_be));
            check($sformatf("v%0d bus_we", idx), 32'(we0), 32'(e.we));
            check($sformatf("v%0d bus_stable", idx), 32'(unstable), 32'd0);
            if (e.we) check($sformatf("v%0d bus_wdata", idx), wd0, e.exp_wdata);
          end
        end
      end else begin
        hold_cnt++;
        if (load_valid || fault) spurious = 1;
        if (bus_req) begin
          if (req_cnt == 0) begin
            a0 = bus_addr; be0 = bus_be; wd0 = bus_wdata; we0 = bus_we;
          end else if (bus_addr !== a0 || bus_be !== be0 || bus_wdata !== wd0 || bus_we !== we0) begin
            unstable = 1;
          end
          bus_ack   = (req_cnt == v.waits);
          bus_rdata = v.rdata;
          req_cnt++;
        end else begin
          bus_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d completion: got no DONE within 40 cycles required DONE", idx);
      exec = 1'b0; dbus_re = 1'b0; dbus_we = 1'b0; bus_ack = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    // Back in IDLE: cause is sticky, no pulses.
    @(negedge clk); #1;
    check($sformatf("v%0d cause_sticky", idx), 32'(fault_cause), 32'(v.exp_cause));
    check($sformatf("v%0d idle_quiet", idx), 32'({hold, bus_req, load_valid, fault}), 32'd0);
  endtask

  initial begin
    //          re    we    f3    addr       sdata         rdata         wt  hd rq baddr      be       wdata         lv    ld             cause
    vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF,  2, 4, 3, 32'h100, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h203, 32'h0,        32'h80FFFFFF,  0, 2, 1, 32'h200, 4'b1000, 32'h0,        1'b1, 32'hFFFFFF80, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h203, 32'h0,        32'h80FFFFFF,  0, 2, 1, 32'h200, 4'b1000, 32'h0,        1'b1, 32'h00000080, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h12,  32'h0000ABCD, 32'h0,         1, 3, 2, 32'h10,  4'b1100, 32'hABCDABCD, 1'b0, 32'h00000080, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h102, 32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h00000080, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h100, 32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h00000080, 2'd3};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, 32'h40,  32'h0,        32'h0,        -1, 5, 4, 32'h40,  4'b1111, 32'h0,        1'b0, 32'h00000080, 2'd2};
    vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h44,  32'h0,        32'h12345678,  3, 5, 4, 32'h44,  4'b1111, 32'h0,        1'b1, 32'h12345678, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 3'd1, 32'h46,  32'h0,        32'h80010000,  0, 2, 1, 32'h44,  4'b1100, 32'h0,        1'b1, 32'hFFFF8001, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 3'd5, 32'h46,  32'h0,        32'h80010000,  0, 2, 1, 32'h44,  4'b1100, 32'h0,        1'b1, 32'h00008001, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 32'h1,   32'h000000A5, 32'h0,         0, 2, 1, 32'h0,   4'b0010, 32'hA5A5A5A5, 1'b0, 32'h00008001, 2'd0};
    vecs[11] = '{1'b1, 1'b1, 3'd2, 32'h0,   32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h00008001, 2'd3};
    vecs[12] = '{1'b1, 1'b0, 3'd7, 32'h0,   32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h00008001, 2'd3};
    vecs[13] = '{1'b0, 1'b1, 3'd1, 32'h11,  32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h00008001, 2'd1};
    vecs[14] = '{1'b1, 1'b0, 3'd1, 32'h20,  32'h0,        32'h12347FFF,  0, 2, 1, 32'h20,  4'b0011, 32'h0,        1'b1, 32'h00007FFF, 2'd0};
    vecs[15] = '{1'b0, 1'b1, 3'd2, 32'h8,   32'hCAFEF00D, 32'h0,         2, 4, 3, 32'h8,   4'b1111, 32'hCAFEF00D, 1'b0, 32'h00007FFF, 2'd0};

    // Reset state.
    #3;
    check("reset_ctrl", 32'({hold, bus_req, bus_we, load_valid, fault}), 32'd0);
    check("reset_load_data", load_data, 32'd0);
    check("reset_fault_cause", 32'(fault_cause), 32'd0);
    check("reset_bus", {bus_addr[27:0], bus_be}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Stray ack and exec-less strobes are ignored.
    begin
      bit stray = 0;
      @(negedge clk);
      dbus_re = 1'b1; funct3 = 3'd2; addr = 32'h300; bus_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
        #1;
        if (hold || bus_req || load_valid || fault) stray = 1;
        @(negedge clk);
      end
      dbus_re = 1'b0; bus_ack = 1'b0;
      check("stray_inputs_quiet", 32'(stray), 32'd0);
    end

    // Reset pulled mid-REQ.
    begin
      bit pulse = 0;
      @(negedge clk);
      exec = 1'b1; dbus_re = 1'b1; funct3 = 3'd2; addr = 32'h300; bus_ack = 1'b0;
      @(negedge clk); #1;
      check("abort_in_req", 32'(bus_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("abort_bus_req", 32'(bus_req), 32'd0);
      check("abort_hold", 32'(hold), 32'd0);
      check("abort_load_data", load_data, 32'd0);
      check("abort_fault_cause", 32'(fault_cause), 32'd0);
      exec = 1'b0; dbus_re = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
        #1;
        if (load_valid || fault || bus_req) pulse = 1;
        @(negedge clk);
      end
      check("abort_no_pulse", 32'(pulse), 32'd0);
    end

    run_vec(99, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
